// File: rtl/lt1185_seq_pkg.sv
// Shared definitions for the LT1185 rail sequencer.
//   seq_state_t  : sequencer FSM states
//   IDX_W        : width of the rail index and of fault_rail
//   RETRY_W      : width of the retry counter
//   RETRY_SAT    : saturation value of the retry counter
//   timer_width(): bits needed by a down-counter that must hold the largest
//                  of the three delay parameters
package lt1185_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    SETTLE,
    ON,
    RAMP_DOWN,
    FAULT,
    BACKOFF,
    LOCKOUT
  } seq_state_t;

  localparam int IDX_W   = 3;
  localparam int RETRY_W = 4;
  localparam logic [RETRY_W-1:0] RETRY_SAT = 4'hF;

  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lt1185_pgood_sync.sv
// Two-flop synchroniser for the asynchronous regulator power-good pins.
//   clk    in  system clock
//   rst_n  in  async active-low clear of both flop stages
//   pgood  in  WIDTH raw power-good pins
//   ps     out WIDTH synchronised power-good, two clk cycles behind pgood
module lt1185_pgood_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pgood,
  output logic [WIDTH-1:0] ps
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= pgood;
      sync_reg <= meta_reg;
    end
  end

  assign ps = sync_reg;

endmodule

// File: rtl/lt1185_rail_sequencer.sv
// Power sequencer for a bank of LT1185 regulator rails.
// Rails come up in index order, each one gated on its own power-good, and go
// down in reverse order. A rail losing power-good (or never reaching it) drops
// every rail at once, then the bank is retried after a back-off period until
// the retry budget is spent, at which point it locks out.
//   clk        in   system clock
//   rst_n      in   async active-low reset
//   pwr_req    in   1 = bring rails up, 0 = take rails down
//   pgood      in   N_RAILS async power-good pins
//   en         out  N_RAILS regulator enables
//   pwr_ok     out  all rails up and settled
//   fault      out  sticky fault flag (cleared on reaching ON or IDLE)
//   fault_rail out  index of the rail that caused the most recent fault
//   retry_cnt  out  faults since the last visit to IDLE (saturating)
//   lockout    out  retry budget exhausted, waiting for pwr_req=0
module lt1185_rail_sequencer
  import lt1185_seq_pkg::*;
#(
  parameter int N_RAILS     = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int SETTLE_CYC  = 64,
  parameter int BACKOFF_CYC = 4096,
  parameter int MAX_RETRY   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pwr_req,
  input  logic [N_RAILS-1:0] pgood,
  output logic [N_RAILS-1:0] en,
  output logic               pwr_ok,
  output logic               fault,
  output logic [IDX_W-1:0]   fault_rail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               lockout
);

  localparam int TIMER_W = timer_width(TIMEOUT_CYC, SETTLE_CYC, BACKOFF_CYC);

  // Reload values are one less than the dwell: the expiry is seen on the
  // cycle the counter already reads zero.
  localparam logic [TIMER_W-1:0] T_TIMEOUT = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] T_SETTLE  = TIMER_W'(SETTLE_CYC - 1);
  localparam logic [TIMER_W-1:0] T_BACKOFF = TIMER_W'(BACKOFF_CYC - 1);
  localparam logic [TIMER_W-1:0] T_ONE     = TIMER_W'(1);

  localparam logic [N_RAILS-1:0] RAIL0    = N_RAILS'(1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_RAILS - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
  localparam logic [RETRY_W-1:0] MAX_R    = RETRY_W'(MAX_RETRY);

  seq_state_t         state;
  logic [IDX_W-1:0]   idx;
  logic [TIMER_W-1:0] timer;

  logic [N_RAILS-1:0] ps;
  logic [N_RAILS-1:0] sel;
  logic               ps_sel;
  logic               timer_zero;
  logic               chk_state;
  logic               chk_cur;
  logic [N_RAILS-1:0] flt_mask;
  logic               flt_any;
  logic [IDX_W-1:0]   flt_rail;
  logic               timeout_hit;
  logic               fault_go;
  logic [IDX_W-1:0]   fault_src;

  lt1185_pgood_sync #(
    .WIDTH(N_RAILS)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .pgood(pgood),
    .ps   (ps)
  );

  // One-hot select of the rail currently being stepped.
  assign sel        = RAIL0 << idx;
  assign ps_sel     = |(ps & sel);
  assign timer_zero = (timer == '0);

  // Rails below idx are always supervised; the rail at idx joins once its
  // own power-good has been seen (SETTLE and ON).
  assign chk_state = (state == RAMP_UP) || (state == SETTLE) || (state == ON);
  assign chk_cur   = (state == SETTLE) || (state == ON);

  generate
    for (genvar gi = 0; gi < N_RAILS; gi++) begin : g_flt
      assign flt_mask[gi] = chk_state && en[gi] && !ps[gi] &&
                            ((IDX_W'(gi) < idx) || (chk_cur && (IDX_W'(gi) == idx)));
    end
  endgenerate

  assign flt_any = |flt_mask;

  // Walk downward so the lowest failing rail is the one that sticks.
  always_comb begin
    flt_rail = '0;
    for (int j = N_RAILS - 1; j >= 0; j--) begin
      if (flt_mask[j]) flt_rail = IDX_W'(j);
    end
  end

  // A ramp timeout only counts if nothing of higher priority happens this
  // cycle: a supervised-rail fault, a request drop, or the rail arriving.
  assign timeout_hit = (state == RAMP_UP) && pwr_req && !ps_sel && timer_zero;
  assign fault_go    = flt_any || timeout_hit;
  assign fault_src   = flt_any ? flt_rail : idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      timer      <= '0;
      en         <= '0;
      pwr_ok     <= 1'b0;
      fault      <= 1'b0;
      fault_rail <= '0;
      retry_cnt  <= '0;
      lockout    <= 1'b0;
    end else if (fault_go) begin
      // Drop every rail in the same edge that detects the problem.
      state      <= FAULT;
      en         <= '0;
      pwr_ok     <= 1'b0;
      fault      <= 1'b1;
      fault_rail <= fault_src;
      retry_cnt  <= (retry_cnt == RETRY_SAT) ? RETRY_SAT : retry_cnt + 4'd1;
    end else begin
      case (state)
        IDLE: begin
          if (pwr_req) begin
            state <= RAMP_UP;
            idx   <= '0;
            en    <= RAIL0;
            timer <= T_TIMEOUT;
          end
        end

        RAMP_UP: begin
          if (!pwr_req) begin
            state <= RAMP_DOWN;
            en    <= en & ~sel;
            timer <= T_SETTLE;
          end else if (ps_sel) begin
            state <= SETTLE;
            timer <= T_SETTLE;
          end else begin
            timer <= timer - T_ONE;
          end
        end

        SETTLE: begin
          if (!pwr_req) begin
            state <= RAMP_DOWN;
            en    <= en & ~sel;
            timer <= T_SETTLE;
          end else if (timer_zero) begin
            if (idx < LAST_IDX) begin
              state <= RAMP_UP;
              idx   <= idx + IDX_ONE;
              en    <= en | (sel << 1);
              timer <= T_TIMEOUT;
            end else begin
              state  <= ON;
              pwr_ok <= 1'b1;
              fault  <= 1'b0;
            end
          end else begin
            timer <= timer - T_ONE;
          end
        end

        ON: begin
          if (!pwr_req) begin
            state  <= RAMP_DOWN;
            pwr_ok <= 1'b0;
            en     <= en & ~sel;
            timer  <= T_SETTLE;
          end
        end

        // en[idx] is already low on entry; after the dwell step to idx-1.
        RAMP_DOWN: begin
          if (timer_zero) begin
            if (idx == '0) begin
              state     <= IDLE;
              retry_cnt <= '0;
              fault     <= 1'b0;
            end else begin
              idx   <= idx - IDX_ONE;
              en    <= en & ~(sel >> 1);
              timer <= T_SETTLE;
            end
          end else begin
            timer <= timer - T_ONE;
          end
        end

        // retry_cnt already holds the incremented count here.
        FAULT: begin
          if (retry_cnt < MAX_R) begin
            state <= BACKOFF;
            timer <= T_BACKOFF;
          end else begin
            state   <= LOCKOUT;
            lockout <= 1'b1;
          end
        end

        BACKOFF: begin
          if (timer_zero) begin
            if (pwr_req) begin
              state <= RAMP_UP;
              idx   <= '0;
              en    <= RAIL0;
              timer <= T_TIMEOUT;
            end else begin
              state     <= IDLE;
              retry_cnt <= '0;
              fault     <= 1'b0;
            end
          end else begin
            timer <= timer - T_ONE;
          end
        end

        LOCKOUT: begin
          if (!pwr_req) begin
            state     <= IDLE;
            lockout   <= 1'b0;
            retry_cnt <= '0;
            fault     <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          en    <= '0;
        end
      endcase
    end
  end

endmodule
